operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
- Single-slot operand fetch stage directly upstream of the register-file read multiplexer.
- Holds one issued uop and drives one virtual read request per source operand.
- Retries reads the multiplexer does not grant, captures returned data one cycle after the grant, and snoops writeback ports to bypass or supersede reads.
- Presents the uop with all operand values to execute through a valid/ready handshake.

Parameters:
- NUM_SRC, 2: source operands per uop; one virtual read port each.
- TAG_W, 7: register tag width; tag 0 is the hard-zero register.
- DATA_W, 32: operand width.
- OP_W, 48: opaque uop payload width.
- NUM_WB, 2: writeback snoop ports.
- STARVE_LIM, 8: consecutive denied cycles before OUT_starve asserts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- IN_flush  in  1  discard slot contents.
- IN_valid  in  1  uop offered by issue.
- OUT_ready  out  1  slot can accept a uop this cycle.
- IN_op  in  OP_W  uop payload.
- IN_src_tag  in  NUM_SRC*TAG_W  source tags.
- OUT_read_valid  out  NUM_SRC  read request per source.
- OUT_read_tag  out  NUM_SRC*TAG_W  request tags.
- IN_read_ready  in  NUM_SRC  grant from the read mux, same cycle as request.
- IN_read_data  in  NUM_SRC*DATA_W  read data, valid the cycle after grant.
- IN_wb_valid  in  NUM_WB  writeback valid.
- IN_wb_tag  in  NUM_WB*TAG_W  writeback tags.
- IN_wb_data  in  NUM_WB*DATA_W  writeback data.
- OUT_valid  out  1  uop plus operands complete.
- IN_out_ready  in  1  execute accepts.
- OUT_op  out  OP_W  held payload.
- OUT_src_data  out  NUM_SRC*DATA_W  operand values.
- OUT_starve  out  1  some source denied for STARVE_LIM or more consecutive cycles.

Behaviour:
- Reset (async): slot empty, every source DONE, all data and counters 0.
  - Outputs: OUT_valid=0, OUT_read_valid=0, OUT_starve=0, OUT_ready=1; OUT_op and OUT_src_data are 0.
- Accept:
  - OUT_ready = !IN_flush && (slot empty || (OUT_valid && IN_out_ready)).
  - On IN_valid && OUT_ready, register the payload and tags.
  - Per source: tag==0 -> DONE with data 0; otherwise -> REQ.
- Per-source FSM (DONE, REQ, WAIT):
  - REQ: OUT_read_valid[i]=1 with the registered tag. IN_read_ready[i]=1 -> WAIT; else stay in REQ and retry next cycle.
  - WAIT: the following cycle, capture IN_read_data[i] and go to DONE.
  - No requests are ever driven from DONE or WAIT, or while the slot is empty.
- Bypass:
  - In REQ or WAIT, any IN_wb_valid[k] with IN_wb_tag[k]==tag[i] captures IN_wb_data[k] and forces DONE.
  - Lowest k wins when several ports match.
  - A bypass in REQ suppresses that cycle's request (OUT_read_valid[i]=0).
  - Read data returning for a superseded WAIT is ignored.
- Completion: OUT_valid=1 when the slot is occupied and all sources are DONE.
  - Outputs stay stable while OUT_valid && !IN_out_ready.
  - When OUT_valid && IN_out_ready, the slot empties unless a new uop enters the same cycle.
- Latency from accept edge, unstalled:
  - Read granted in first cycle: OUT_valid on the 3rd cycle.
  - All sources bypassed in first cycle: OUT_valid on the 2nd cycle.
  - All tags 0: OUT_valid on the 1st cycle.
- Starve counter:
  - Per-source saturating counter increments each cycle in REQ with IN_read_ready=0; cleared on grant, bypass or flush.
  - OUT_starve = OR over sources of (count >= STARVE_LIM), registered.
- Flush:
  - Slot empties next edge, all sources go to DONE, counters clear, OUT_valid drops.
  - No accept during the flush cycle. Read data returning after the flush is ignored.
- Mid-operation reset behaves identically to flush, and is asynchronous.

Test Plan:
- Tags {5,9}, both granted immediately, data returned in the next cycle {0xAA,0xBB} -> read_valid=11 for one cycle; OUT_valid on the 3rd cycle with src={0xAA,0xBB}.
- Tags {5,9}, src1 denied for 3 cycles then granted -> src1 re-requests tag 9 each cycle; OUT_valid 3 cycles later than the unstalled case; src0 data unchanged.
- Tags {0,0} -> no read_valid ever; OUT_valid on the 1st cycle with src={0,0}.
- Tag 5 in WAIT while wb0 writes tag 5=0x11 -> next cycle's RF data 0x99 is ignored; operand = 0x11. Same case with wb0 and wb1 both writing tag 5 -> wb0 data wins.
- Denied for 10 cycles with STARVE_LIM=8 -> OUT_starve rises after the 8th denial and clears the cycle after the grant.
- IN_flush while WAIT, with IN_valid=1 the same cycle -> OUT_ready=0; slot empty next cycle; late RF data is not captured; a new uop is accepted the cycle after.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// Bundle of issue, register-read, writeback-snoop and execute signals
// around the operand fetch stage. The stage connects through the slave
// modport. The environment (issue, read mux, writeback, execute) uses master.
interface operand_fetch_stage_if #(
  parameter int NUM_SRC = 2,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 48,
  parameter int NUM_WB  = 2
);
  // issue side
  logic                        IN_flush;
  logic                        IN_valid;
  logic                        OUT_ready;
  logic [OP_W-1:0]             IN_op;
  logic [NUM_SRC*TAG_W-1:0]    IN_src_tag;
  // register-file read mux
  logic [NUM_SRC-1:0]          OUT_read_valid;
  logic [NUM_SRC*TAG_W-1:0]    OUT_read_tag;
  logic [NUM_SRC-1:0]          IN_read_ready;
  logic [NUM_SRC*DATA_W-1:0]   IN_read_data;
  // writeback snoop
  logic [NUM_WB-1:0]           IN_wb_valid;
  logic [NUM_WB*TAG_W-1:0]     IN_wb_tag;
  logic [NUM_WB*DATA_W-1:0]    IN_wb_data;
  // execute side
  logic                        OUT_valid;
  logic                        IN_out_ready;
  logic [OP_W-1:0]             OUT_op;
  logic [NUM_SRC*DATA_W-1:0]   OUT_src_data;
  logic                        OUT_starve;

  modport slave (
    input  IN_flush, IN_valid, IN_op, IN_src_tag, IN_read_ready, IN_read_data,
           IN_wb_valid, IN_wb_tag, IN_wb_data, IN_out_ready,
    output OUT_ready, OUT_read_valid, OUT_read_tag, OUT_valid, OUT_op,
           OUT_src_data, OUT_starve
  );

  modport master (
    output IN_flush, IN_valid, IN_op, IN_src_tag, IN_read_ready, IN_read_data,
           IN_wb_valid, IN_wb_tag, IN_wb_data, IN_out_ready,
    input  OUT_ready, OUT_read_valid, OUT_read_tag, OUT_valid, OUT_op,
           OUT_src_data, OUT_starve
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Single-slot operand fetch stage. Holds one uop and fetches each source
// operand through its own virtual read port. Denied reads are retried. Data
// is captured the cycle after the grant. Writeback snoops can satisfy a pending
// operand early. The uop goes to execute once every operand is known.
module operand_fetch_stage #(
  parameter int NUM_SRC    = 2,
  parameter int TAG_W      = 7,
  parameter int DATA_W     = 32,
  parameter int OP_W       = 48,
  parameter int NUM_WB     = 2,
  parameter int STARVE_LIM = 8
) (
  input logic                  clk,
  input logic                  rst,
  operand_fetch_stage_if.slave bus
);

  // Per-source states: DONE = value known, REQ = must (re)request,
  // WAIT = granted last cycle, data arrives this cycle.
  localparam logic [1:0] S_DONE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int               CNT_W   = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

  logic                 slot_q, slot_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [TAG_W-1:0]     tag_q  [NUM_SRC];
  logic [TAG_W-1:0]     tag_d  [NUM_SRC];
  logic [1:0]           st_q   [NUM_SRC];
  logic [1:0]           st_d   [NUM_SRC];
  logic [DATA_W-1:0]    data_q [NUM_SRC];
  logic [DATA_W-1:0]    data_d [NUM_SRC];
  logic [CNT_W-1:0]     cnt_q  [NUM_SRC];
  logic [CNT_W-1:0]     cnt_d  [NUM_SRC];
  logic                 starve_q, starve_d;

  logic                 byp_hit  [NUM_SRC];
  logic [DATA_W-1:0]    byp_data [NUM_SRC];
  logic                 all_done;
  logic                 out_valid;
  logic                 out_ready;
  logic                 accept;
  logic                 retire;

  // Writeback match per pending source. The descending scan leaves the lowest port as winner.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      byp_hit[i]  = 1'b0;
      byp_data[i] = '0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (st_q[i] != S_DONE && bus.IN_wb_valid[k] &&
            bus.IN_wb_tag[k*TAG_W +: TAG_W] == tag_q[i]) begin
          byp_hit[i]  = 1'b1;
          byp_data[i] = bus.IN_wb_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Handshake and read-request outputs.
  always_comb begin
    all_done = 1'b1;
    bus.OUT_read_valid = '0;
    bus.OUT_read_tag   = '0;
    bus.OUT_src_data   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (st_q[i] != S_DONE) all_done = 1'b0;
      bus.OUT_read_valid[i] = slot_q && st_q[i] == S_REQ && !byp_hit[i];
      bus.OUT_read_tag[i*TAG_W +: TAG_W]   = tag_q[i];
      bus.OUT_src_data[i*DATA_W +: DATA_W] = data_q[i];
    end
    out_valid = slot_q && all_done;
    out_ready = !bus.IN_flush && (!slot_q || (out_valid && bus.IN_out_ready));
    accept    = bus.IN_valid && out_ready;
    retire    = out_valid && bus.IN_out_ready;
  end

  assign bus.OUT_valid  = out_valid;
  assign bus.OUT_ready  = out_ready;
  assign bus.OUT_op     = op_q;
  assign bus.OUT_starve = starve_q;

  // Next-state: flush, then accept, then retire, then per-source progress.
  always_comb begin
    slot_d   = slot_q;
    op_d     = op_q;
    starve_d = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      tag_d[i]  = tag_q[i];
      st_d[i]   = st_q[i];
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i];
    end

    if (bus.IN_flush) begin
      slot_d = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        st_d[i]  = S_DONE;
        cnt_d[i] = '0;
      end
    end else if (accept) begin
      slot_d = 1'b1;
      op_d   = bus.IN_op;
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_d[i]  = bus.IN_src_tag[i*TAG_W +: TAG_W];
        st_d[i]   = (tag_d[i] == '0) ? S_DONE : S_REQ;
        data_d[i] = '0;
        cnt_d[i]  = '0;
      end
    end else if (retire) begin
      slot_d = 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (byp_hit[i]) begin
          st_d[i]   = S_DONE;
          data_d[i] = byp_data[i];
          cnt_d[i]  = '0;
        end else if (st_q[i] == S_WAIT) begin
          st_d[i]   = S_DONE;
          data_d[i] = bus.IN_read_data[i*DATA_W +: DATA_W];
        end else if (st_q[i] == S_REQ) begin
          if (bus.IN_read_ready[i]) begin
            st_d[i]  = S_WAIT;
            cnt_d[i] = '0;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end

    for (int i = 0; i < NUM_SRC; i++) begin
      if (cnt_d[i] >= CNT_MAX) starve_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to an empty slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= 1'b0;
      op_q     <= '0;
      starve_q <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_q[i]  <= '0;
        st_q[i]   <= S_DONE;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment, so every register samples pre-edge values.
      slot_q   <= slot_d;
      op_q     <= op_d;
      starve_q <= starve_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_q[i]  <= tag_d[i];
        st_q[i]   <= st_d[i];
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule
